// File: rtl/alu_arb_pkg.sv
// Shared widths, the issued-operation record and the round-robin picker
// used by the ALU request arbiter.
package alu_arb_pkg;

    localparam int ALU_OP_W  = 8;
    localparam int ALU_OUT_W = 16;
    localparam int ALU_OPC_W = 3;
    localparam int MAX_REQ   = 8;

    typedef struct packed {
        logic [ALU_OP_W-1:0]  a;
        logic [ALU_OP_W-1:0]  b;
        logic [ALU_OPC_W-1:0] opcode;
    } alu_op_t;

    // One-hot grant to the first valid requester at or after ptr, wrapping at numReq.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] vld,
        input logic [2:0]         ptr,
        input int                 numReq
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int                 idxInt;
        logic [2:0]         idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idxInt = (int'(ptr) + k) % numReq;
            idx    = 3'(idxInt);
            if ((k < numReq) && !found && vld[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Requester, response and ALU-side signal bundle of the ALU request arbiter.
// slave is the arbiter's view; master is the requesters/ALU view.
interface alu_req_arbiter_if #(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]                         req_vld;
    logic [NUM_REQ-1:0]                         req_rdy;
    logic [NUM_REQ*alu_arb_pkg::ALU_OP_W-1:0]   req_a;
    logic [NUM_REQ*alu_arb_pkg::ALU_OP_W-1:0]   req_b;
    logic [NUM_REQ*alu_arb_pkg::ALU_OPC_W-1:0]  req_opcode;
    logic [NUM_REQ-1:0]                         rsp_vld;
    logic [alu_arb_pkg::ALU_OUT_W-1:0]          rsp_out;
    logic                                       rsp_err;
    logic                                       alu_vld;
    logic [alu_arb_pkg::ALU_OP_W-1:0]           alu_a;
    logic [alu_arb_pkg::ALU_OP_W-1:0]           alu_b;
    logic [alu_arb_pkg::ALU_OPC_W-1:0]          alu_opcode;
    logic [alu_arb_pkg::ALU_OUT_W-1:0]          alu_out;
    logic                                       alu_opVld;
    logic                                       busy;
    logic                                       err_unexp;

    modport slave (
        input  req_vld, req_a, req_b, req_opcode, alu_out, alu_opVld,
        output req_rdy, rsp_vld, rsp_out, rsp_err,
               alu_vld, alu_a, alu_b, alu_opcode, busy, err_unexp
    );

    modport master (
        output req_vld, req_a, req_b, req_opcode, alu_out, alu_opVld,
        input  req_rdy, rsp_vld, rsp_out, rsp_err,
               alu_vld, alu_a, alu_b, alu_opcode, busy, err_unexp
    );

endinterface

// File: rtl/alu_arb_tag_fifo.sv
// In-order FIFO of requester tags for ALU operations still in flight.
module alu_arb_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushData,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_head   = r_mem[r_rdPtr];
    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_doPop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin sharing of one 8x8->16 ALU between NUM_REQ requesters, with
// in-order result routing. Optional head-of-line timeout: ALU_ARB_TIMEOUT_EN.
module alu_req_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYC     = 64
) (
    input logic              clk,
    input logic              reset,
    alu_req_arbiter_if.slave bus
);

    import alu_arb_pkg::*;

    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [TAG_W-1:0]     r_ptr;
    logic [MAX_REQ-1:0]   w_vldWide;
    logic [MAX_REQ-1:0]   w_pickWide;
    logic                 w_unusedPick;
    logic [NUM_REQ-1:0]   w_grant;
    logic                 w_credit;
    logic                 w_hs;
    logic [TAG_W-1:0]     w_hsIdx;
    alu_op_t              w_hsOp;
    logic [TAG_W-1:0]     w_head;
    logic [CNT_W-1:0]     w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_aluPop;
    logic                 w_timeoutPop;
    logic                 w_pop;

    logic                 r_aluVld;
    alu_op_t              r_aluOp;
    logic [NUM_REQ-1:0]   r_rspVld;
    logic [ALU_OUT_W-1:0] r_rspOut;
    logic                 r_rspErr;
    logic                 r_errUnexp;

    // No pop bypass: a slot freed this cycle is only usable next cycle.
    assign w_credit     = ~w_full;
    assign w_vldWide    = MAX_REQ'(bus.req_vld);
    assign w_pickWide   = rr_pick(w_vldWide, 3'(r_ptr), NUM_REQ);
    assign w_unusedPick = ^w_pickWide;
    assign w_grant      = w_credit ? (w_pickWide[NUM_REQ-1:0] & bus.req_vld) : '0;
    assign w_hs         = |(w_grant & bus.req_vld);

    always_comb begin
        w_hsIdx = '0;
        w_hsOp  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_hsIdx       = TAG_W'(i);
                w_hsOp.a      = bus.req_a[i*ALU_OP_W +: ALU_OP_W];
                w_hsOp.b      = bus.req_b[i*ALU_OP_W +: ALU_OP_W];
                w_hsOp.opcode = bus.req_opcode[i*ALU_OPC_W +: ALU_OPC_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= (w_hsIdx == TAG_W'(NUM_REQ - 1)) ? '0 : w_hsIdx + 1'b1;
        end
    end

    // Operands hold their last value between issues; only alu_vld pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_aluVld <= 1'b0;
            r_aluOp  <= '0;
        end else begin
            r_aluVld <= w_hs;
            if (w_hs) begin
                r_aluOp <= w_hsOp;
            end
        end
    end

    alu_arb_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tagFifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_hs),
        .i_pushData (w_hsIdx),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    assign w_aluPop = bus.alu_opVld & ~w_empty;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int AGE_W = $clog2(TIMEOUT_CYC + 1);

    logic [AGE_W-1:0] r_age;

    // Age counts cycles the current head has waited; a real result wins a tie.
    always_ff @(posedge clk) begin
        if (reset || w_empty || w_pop) begin
            r_age <= '0;
        end else begin
            r_age <= r_age + 1'b1;
        end
    end

    assign w_timeoutPop = ~w_empty & ~bus.alu_opVld &
                          ((r_age + 1'b1) == AGE_W'(TIMEOUT_CYC));
`else
    logic w_unusedTimeout;

    assign w_timeoutPop    = 1'b0;
    assign w_unusedTimeout = (TIMEOUT_CYC != 0);
`endif

    assign w_pop = w_aluPop | w_timeoutPop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rspVld   <= '0;
            r_rspOut   <= '0;
            r_rspErr   <= 1'b0;
            r_errUnexp <= 1'b0;
        end else begin
            r_rspVld <= '0;
            r_rspErr <= 1'b0;
            if (w_pop) begin
                r_rspVld <= NUM_REQ'(1) << w_head;
                r_rspOut <= w_aluPop ? bus.alu_out : '0;
                r_rspErr <= w_timeoutPop;
            end
            if (bus.alu_opVld && w_empty) begin
                r_errUnexp <= 1'b1;
            end
        end
    end

    assign bus.req_rdy    = w_grant;
    assign bus.alu_vld    = r_aluVld;
    assign bus.alu_a      = r_aluOp.a;
    assign bus.alu_b      = r_aluOp.b;
    assign bus.alu_opcode = r_aluOp.opcode;
    assign bus.rsp_vld    = r_rspVld;
    assign bus.rsp_out    = r_rspOut;
    assign bus.rsp_err    = r_rspErr;
    assign bus.busy       = (w_count != '0);
    assign bus.err_unexp  = r_errUnexp;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios plus randomized traffic
// against a queue-based model. Build with ALU_ARB_TIMEOUT_EN for the timeout case.
module tb_alu_req_arbiter;

    import alu_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int MAXO = 4;
`ifdef ALU_ARB_TIMEOUT_EN
    localparam int TCYC = 8;
`else
    localparam int TCYC = 64;
`endif

    logic clk = 1'b0;
    logic reset;

    alu_req_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    alu_req_arbiter #(
        .NUM_REQ         (NREQ),
        .MAX_OUTSTANDING (MAXO),
        .TIMEOUT_CYC     (TCYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nMis = 0;

    // Model: outstanding requester tags in issue order, RR pointer, sticky error.
    int              mQ[$];
    int              mPtr;
    logic            eErr;
    logic [NREQ-1:0] mGrantNow;
    logic            mBusyNow;
    logic            eAluVld;
    logic [7:0]      eA;
    logic [7:0]      eB;
    logic [2:0]      eOpc;
    logic [NREQ-1:0] eRspVld;
    logic [15:0]     eRspOut;

    function automatic void model_reset();
        mQ.delete();
        mPtr    = 0;
        eErr    = 1'b0;
        eAluVld = 1'b0;
        eA      = '0;
        eB      = '0;
        eOpc    = '0;
        eRspVld = '0;
        eRspOut = '0;
    endfunction

    // Call once per cycle after inputs are set, before the clock edge.
    function automatic void model_step();
        int g;
        int i;
        int h;
        g = -1;
        mBusyNow = (mQ.size() != 0);
        if (mQ.size() < MAXO) begin
            for (int k = 0; k < NREQ; k++) begin
                i = (mPtr + k) % NREQ;
                if (g < 0 && bus.req_vld[i]) g = i;
            end
        end
        mGrantNow = (g < 0) ? '0 : (NREQ'(1) << g);
        eRspVld = '0;
        if (bus.alu_opVld) begin
            if (mQ.size() != 0) begin
                h = mQ.pop_front();
                eRspVld = NREQ'(1) << h;
                eRspOut = bus.alu_out;
            end else begin
                eErr = 1'b1;
            end
        end
        eAluVld = (g >= 0);
        if (g >= 0) begin
            eA   = bus.req_a[g*8 +: 8];
            eB   = bus.req_b[g*8 +: 8];
            eOpc = bus.req_opcode[g*3 +: 3];
            mQ.push_back(g);
            mPtr = (g + 1) % NREQ;
        end
    endfunction

    task automatic clear_inputs();
        bus.req_vld    = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_opcode = '0;
        bus.alu_out    = '0;
        bus.alu_opVld  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        nVec++; if (bus.alu_vld !== 1'b0) begin nMis++; $display("[TB] FAIL reset_alu_vld got=%b want=0", bus.alu_vld); end
        nVec++; if ({bus.alu_a, bus.alu_b, bus.alu_opcode} !== 19'h0) begin nMis++; $display("[TB] FAIL reset_alu_ops got=%h/%h/%h want=0", bus.alu_a, bus.alu_b, bus.alu_opcode); end
        nVec++; if (bus.rsp_vld !== 4'b0000 || bus.rsp_out !== 16'h0 || bus.rsp_err !== 1'b0) begin nMis++; $display("[TB] FAIL reset_rsp got=%b/%h/%b want=0", bus.rsp_vld, bus.rsp_out, bus.rsp_err); end
        nVec++; if (bus.err_unexp !== 1'b0 || bus.busy !== 1'b0) begin nMis++; $display("[TB] FAIL reset_flags err=%b busy=%b want=0/0", bus.err_unexp, bus.busy); end
        nVec++; if (bus.req_rdy !== 4'b0000) begin nMis++; $display("[TB] FAIL reset_rdy_idle got=%b want=0000", bus.req_rdy); end
        bus.req_vld = 4'b1010; #1;
        nVec++; if (bus.req_rdy !== 4'b0010) begin nMis++; $display("[TB] FAIL reset_rdy_1010 got=%b want=0010", bus.req_rdy); end
        bus.req_vld = 4'b1111; #1;
        nVec++; if (bus.req_rdy !== 4'b0001) begin nMis++; $display("[TB] FAIL reset_rdy_1111 got=%b want=0001", bus.req_rdy); end
        bus.req_vld = 4'b0000;
    endtask

    task automatic test_single_op();
        do_reset();
        bus.req_vld          = 4'b0100;
        bus.req_a[2*8 +: 8]  = 8'h05;
        bus.req_b[2*8 +: 8]  = 8'h03;
        bus.req_opcode[6 +: 3] = 3'd0;
        model_step(); #1;
        nVec++; if (bus.req_rdy !== 4'b0100) begin nMis++; $display("[TB] FAIL single_rdy got=%b want=0100", bus.req_rdy); end
        step();
        bus.req_vld = '0;
        nVec++; if (bus.alu_vld !== 1'b1 || bus.alu_a !== 8'h05 || bus.alu_b !== 8'h03 || bus.alu_opcode !== 3'd0) begin
            nMis++; $display("[TB] FAIL single_issue got=%b %h %h %0d want=1 05 03 0", bus.alu_vld, bus.alu_a, bus.alu_b, bus.alu_opcode); end
        model_step(); step();
        nVec++; if (bus.alu_vld !== 1'b0) begin nMis++; $display("[TB] FAIL single_vld_pulse got=%b want=0", bus.alu_vld); end
        bus.alu_opVld = 1'b1;
        bus.alu_out   = 16'h0008;
        model_step(); step();
        bus.alu_opVld = 1'b0;
        nVec++; if (bus.rsp_vld !== 4'b0100 || bus.rsp_out !== 16'h0008) begin
            nMis++; $display("[TB] FAIL single_rsp got=%b %h want=0100 0008", bus.rsp_vld, bus.rsp_out); end
        nVec++; if (bus.busy !== 1'b0) begin nMis++; $display("[TB] FAIL single_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        do_reset();
        bus.req_vld = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*8 +: 8]      = 8'(8'h10 + i);
            bus.req_b[i*8 +: 8]      = 8'(8'h20 + i);
            bus.req_opcode[i*3 +: 3] = 3'(i);
        end
        for (int k = 0; k < 6; k++) begin
            want = (k < 4) ? (4'b0001 << k) : 4'b0000;
            model_step(); #1;
            nVec++; if (bus.req_rdy !== want) begin nMis++; $display("[TB] FAIL rr_grant k=%0d got=%b want=%b", k, bus.req_rdy, want); end
            step();
            nVec++; if (bus.alu_vld !== (k < 4) || (k < 4 && bus.alu_a !== 8'(8'h10 + k))) begin
                nMis++; $display("[TB] FAIL rr_issue k=%0d got=%b %h want=%b %h", k, bus.alu_vld, bus.alu_a, (k < 4), 8'(8'h10 + k)); end
        end
        nVec++; if (bus.busy !== 1'b1) begin nMis++; $display("[TB] FAIL rr_busy got=%b want=1", bus.busy); end
    endtask

    task automatic test_full_push_pop();
        logic [3:0] order [4];
        order = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.req_vld   = 4'b1111;
        bus.alu_opVld = 1'b1;
        bus.alu_out   = 16'hBEEF;
        model_step(); #1;
        nVec++; if (bus.req_rdy !== 4'b0000) begin nMis++; $display("[TB] FAIL full_no_bypass got=%b want=0000", bus.req_rdy); end
        step();
        bus.alu_opVld = 1'b0;
        nVec++; if (bus.rsp_vld !== 4'b0001 || bus.rsp_out !== 16'hBEEF) begin
            nMis++; $display("[TB] FAIL full_pop_rsp got=%b %h want=0001 beef", bus.rsp_vld, bus.rsp_out); end
        model_step(); #1;
        nVec++; if (bus.req_rdy !== 4'b0001) begin nMis++; $display("[TB] FAIL full_regrant got=%b want=0001", bus.req_rdy); end
        step();
        nVec++; if (bus.req_rdy !== 4'b0000 || bus.busy !== 1'b1) begin
            nMis++; $display("[TB] FAIL full_refilled rdy=%b busy=%b want=0000 1", bus.req_rdy, bus.busy); end
        bus.req_vld = '0;
        for (int k = 0; k < 4; k++) begin
            bus.alu_opVld = 1'b1;
            bus.alu_out   = 16'(16'h1000 + k);
            model_step(); step();
            nVec++; if (bus.rsp_vld !== order[k] || bus.rsp_out !== 16'(16'h1000 + k)) begin
                nMis++; $display("[TB] FAIL drain_rsp k=%0d got=%b %h want=%b %h", k, bus.rsp_vld, bus.rsp_out, order[k], 16'(16'h1000 + k)); end
        end
        bus.alu_opVld = 1'b0;
        nVec++; if (bus.busy !== 1'b0) begin nMis++; $display("[TB] FAIL drain_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_unexpected();
        bus.alu_opVld = 1'b1;
        bus.alu_out   = 16'h5555;
        model_step(); step();
        bus.alu_opVld = 1'b0;
        nVec++; if (bus.err_unexp !== 1'b1 || bus.rsp_vld !== 4'b0000) begin
            nMis++; $display("[TB] FAIL unexp_set err=%b rsp=%b want=1 0000", bus.err_unexp, bus.rsp_vld); end
        for (int k = 0; k < 3; k++) begin
            model_step(); step();
        end
        nVec++; if (bus.err_unexp !== eErr || eErr !== 1'b1) begin nMis++; $display("[TB] FAIL unexp_sticky got=%b want=1", bus.err_unexp); end
        do_reset();
        nVec++; if (bus.err_unexp !== 1'b0) begin nMis++; $display("[TB] FAIL unexp_clear got=%b want=0", bus.err_unexp); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req_vld = 4'b0111;
        bus.req_a   = 32'hA1B2C3D4;
        bus.req_b   = 32'h11223344;
        for (int k = 0; k < 3; k++) begin
            model_step(); step();
        end
        nVec++; if (bus.busy !== 1'b1 || bus.alu_vld !== 1'b1) begin
            nMis++; $display("[TB] FAIL mid_before busy=%b vld=%b want=1 1", bus.busy, bus.alu_vld); end
        reset       = 1'b1;
        bus.req_vld = 4'b1111;
        step();
        reset = 1'b0;
        model_reset();
        nVec++; if (bus.busy !== 1'b0 || bus.req_rdy !== 4'b0001) begin
            nMis++; $display("[TB] FAIL mid_after busy=%b rdy=%b want=0 0001", bus.busy, bus.req_rdy); end
        nVec++; if (bus.alu_vld !== 1'b0 || bus.alu_a !== 8'h0 || bus.alu_b !== 8'h0 || bus.rsp_vld !== 4'b0000 || bus.err_unexp !== 1'b0) begin
            nMis++; $display("[TB] FAIL mid_outputs vld=%b a=%h b=%h rsp=%b err=%b want=0", bus.alu_vld, bus.alu_a, bus.alu_b, bus.rsp_vld, bus.err_unexp); end
        bus.req_vld = '0;
    endtask

    task automatic test_random();
        int due[$];
        int lastDue;
        int lat;
        int tmp;
        do_reset();
        lastDue = 0;
        for (int c = 0; c < 300; c++) begin
            bus.req_vld    = 4'($urandom);
            bus.req_a      = $urandom;
            bus.req_b      = $urandom;
            bus.req_opcode = 12'($urandom);
            bus.alu_out    = 16'($urandom);
            if (due.size() != 0 && due[0] == c) begin
                tmp = due.pop_front();
                bus.alu_opVld = 1'b1;
            end else begin
                bus.alu_opVld = 1'b0;
            end
            model_step();
            if (mGrantNow != '0) begin
                lat = $urandom_range(3, 1);
                due.push_back((c + 1 + lat > lastDue) ? c + 1 + lat : lastDue + 1);
                lastDue = due[$];
            end
            #1;
            nVec++; if (bus.req_rdy !== mGrantNow) begin nMis++; $display("[TB] FAIL rand_rdy c=%0d got=%b want=%b", c, bus.req_rdy, mGrantNow); end
            nVec++; if (bus.busy !== mBusyNow) begin nMis++; $display("[TB] FAIL rand_busy c=%0d got=%b want=%b", c, bus.busy, mBusyNow); end
            step();
            nVec++; if (bus.alu_vld !== eAluVld || bus.alu_a !== eA || bus.alu_b !== eB || bus.alu_opcode !== eOpc) begin
                nMis++; $display("[TB] FAIL rand_issue c=%0d got=%b %h %h %0d want=%b %h %h %0d", c, bus.alu_vld, bus.alu_a, bus.alu_b, bus.alu_opcode, eAluVld, eA, eB, eOpc); end
            nVec++; if (bus.rsp_vld !== eRspVld || bus.rsp_err !== 1'b0 || (eRspVld != '0 && bus.rsp_out !== eRspOut)) begin
                nMis++; $display("[TB] FAIL rand_rsp c=%0d got=%b %h %b want=%b %h 0", c, bus.rsp_vld, bus.rsp_out, bus.rsp_err, eRspVld, eRspOut); end
            nVec++; if (bus.err_unexp !== eErr) begin nMis++; $display("[TB] FAIL rand_err c=%0d got=%b want=%b", c, bus.err_unexp, eErr); end
        end
        clear_inputs();
    endtask

`ifdef ALU_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        bus.req_vld = 4'b0010;
        step();
        bus.req_vld = '0;
        nVec++; if (bus.alu_vld !== 1'b1) begin nMis++; $display("[TB] FAIL to_issue got=%b want=1", bus.alu_vld); end
        for (int k = 1; k < TCYC; k++) step();
        nVec++; if (bus.rsp_vld !== 4'b0000 || bus.busy !== 1'b1) begin
            nMis++; $display("[TB] FAIL to_early rsp=%b busy=%b want=0000 1", bus.rsp_vld, bus.busy); end
        step();
        nVec++; if (bus.rsp_vld !== 4'b0010 || bus.rsp_err !== 1'b1 || bus.rsp_out !== 16'h0 || bus.busy !== 1'b0) begin
            nMis++; $display("[TB] FAIL to_fire rsp=%b err=%b out=%h busy=%b want=0010 1 0000 0", bus.rsp_vld, bus.rsp_err, bus.rsp_out, bus.busy); end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        model_reset();
        step();
        test_reset();
        test_single_op();
        test_round_robin();
        test_full_push_pop();
        test_unexpected();
        test_reset_mid();
        test_random();
`ifdef ALU_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
